// File: rtl/hazard_forward_unit.sv
// rtl/hazard_forward_unit.sv - operand forwarding selects and load-use stall sequencing for the ID stage
// Optional stall statistics counter: define HAZARD_STALL_COUNTER_EN.
module hazard_forward_unit #(
    parameter int LOAD_LAT = 1,
    parameter int CNT_W    = 16
) (
    input  logic             i_clk,
    input  logic             i_clr,
    input  logic [3:0]       i_rn_id,
    input  logic [3:0]       i_rm_id,
    input  logic [3:0]       i_rs_id,
    input  logic             i_use_a,
    input  logic             i_use_b,
    input  logic             i_use_c,
    input  logic [3:0]       i_idex_rd,
    input  logic             i_idex_rf,
    input  logic             i_idex_load,
    input  logic [3:0]       i_exmem_rd,
    input  logic             i_exmem_rf,
    input  logic [3:0]       i_memwb_rd,
    input  logic             i_memwb_rf,
    input  logic             i_branch_taken,
    output logic [1:0]       o_fwd_a,
    output logic [1:0]       o_fwd_b,
    output logic [1:0]       o_fwd_c,
    output logic             o_pc_le,
    output logic             o_ifid_le,
    output logic             o_ifid_clr,
    output logic             o_idex_nop,
    output logic [CNT_W-1:0] o_stall_count
);

    localparam logic       ST_RUN   = 1'b0;
    localparam logic       ST_STALL = 1'b1;
    localparam logic [3:0] LAT_M1   = 4'(LOAD_LAT - 1);
    localparam logic       MULTI    = (LOAD_LAT > 1);

    logic       r_state;
    logic [3:0] r_cnt;
    logic       w_haz;
    logic       w_stall;
    logic [1:0] w_fwd_a;
    logic [1:0] w_fwd_b;
    logic [1:0] w_fwd_c;

    // Nearest producer wins; a load in EX has no result yet, and R15 (PC) is never forwarded.
    function automatic logic [1:0] fwd_sel(input logic use_s, input logic [3:0] src);
        if (!use_s || src == 4'hF)
            return 2'b00;
        else if (i_idex_rf && !i_idex_load && i_idex_rd == src)
            return 2'b01;
        else if (i_exmem_rf && i_exmem_rd == src)
            return 2'b10;
        else if (i_memwb_rf && i_memwb_rd == src)
            return 2'b11;
        else
            return 2'b00;
    endfunction

    function automatic logic src_hit(input logic use_s, input logic [3:0] src);
        return use_s && (src != 4'hF) && (src == i_idex_rd);
    endfunction

    always_comb begin
        w_fwd_a = fwd_sel(i_use_a, i_rn_id);
        w_fwd_b = fwd_sel(i_use_b, i_rm_id);
        w_fwd_c = fwd_sel(i_use_c, i_rs_id);
        w_haz   = i_idex_load && i_idex_rf &&
                  (src_hit(i_use_a, i_rn_id) || src_hit(i_use_b, i_rm_id) || src_hit(i_use_c, i_rs_id));
        w_stall = (r_state == ST_STALL) || w_haz;
    end

    // Reset is asynchronous, so the outputs are gated by CLR directly rather than by state alone.
    always_comb begin
        o_fwd_a    = i_clr ? w_fwd_a : 2'b00;
        o_fwd_b    = i_clr ? w_fwd_b : 2'b00;
        o_fwd_c    = i_clr ? w_fwd_c : 2'b00;
        o_pc_le    = i_clr && !w_stall;
        o_ifid_le  = i_clr && !w_stall;
        o_ifid_clr = i_clr && !w_stall && i_branch_taken;
        o_idex_nop = !i_clr || w_stall;
    end

    always_ff @(posedge i_clk or negedge i_clr) begin
        if (!i_clr) begin
            r_state <= ST_RUN;
            r_cnt   <= 4'd0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (w_haz && MULTI) begin
                        r_state <= ST_STALL;
                        r_cnt   <= LAT_M1;
                    end
                end
                default: begin
                    r_cnt <= r_cnt - 4'd1;
                    if (r_cnt == 4'd1)
                        r_state <= ST_RUN;
                end
            endcase
        end
    end

`ifdef HAZARD_STALL_COUNTER_EN
    logic [CNT_W-1:0] r_stall_count;

    always_ff @(posedge i_clk or negedge i_clr) begin
        if (!i_clr)
            r_stall_count <= '0;
        else if (!o_pc_le && r_stall_count != {CNT_W{1'b1}})
            r_stall_count <= r_stall_count + 1'b1;
    end

    assign o_stall_count = r_stall_count;
`else
    assign o_stall_count = '0;
`endif

endmodule

// File: tb/tb_hazard_forward_unit.sv
// tb/tb_hazard_forward_unit.sv - directed and randomized checks of hazard_forward_unit against a reference model
module tb_hazard_forward_unit;

    logic       clk = 1'b0;
    logic       clr;
    logic [3:0] rn, rm, rs;
    logic       ua, ub, uc;
    logic [3:0] idex_rd, exmem_rd, memwb_rd;
    logic       idex_rf, idex_load, exmem_rf, memwb_rf;
    logic       bt;

    logic [1:0]  fa1, fb1, fc1, fa3, fb3, fc3;
    logic        pc1, ifle1, ifclr1, nop1, pc3, ifle3, ifclr3, nop3;
    logic [15:0] sc1;
    logic [2:0]  sc3;

    int vectors = 0;
    int miscompares = 0;
    int rem1 = 0, rem3 = 0, cnt1 = 0, cnt3 = 0;

    always #5 clk = ~clk;

    hazard_forward_unit #(.LOAD_LAT(1), .CNT_W(16)) u_lat1 (
        .i_clk(clk), .i_clr(clr), .i_rn_id(rn), .i_rm_id(rm), .i_rs_id(rs),
        .i_use_a(ua), .i_use_b(ub), .i_use_c(uc),
        .i_idex_rd(idex_rd), .i_idex_rf(idex_rf), .i_idex_load(idex_load),
        .i_exmem_rd(exmem_rd), .i_exmem_rf(exmem_rf), .i_memwb_rd(memwb_rd), .i_memwb_rf(memwb_rf),
        .i_branch_taken(bt), .o_fwd_a(fa1), .o_fwd_b(fb1), .o_fwd_c(fc1),
        .o_pc_le(pc1), .o_ifid_le(ifle1), .o_ifid_clr(ifclr1), .o_idex_nop(nop1), .o_stall_count(sc1)
    );

    hazard_forward_unit #(.LOAD_LAT(3), .CNT_W(3)) u_lat3 (
        .i_clk(clk), .i_clr(clr), .i_rn_id(rn), .i_rm_id(rm), .i_rs_id(rs),
        .i_use_a(ua), .i_use_b(ub), .i_use_c(uc),
        .i_idex_rd(idex_rd), .i_idex_rf(idex_rf), .i_idex_load(idex_load),
        .i_exmem_rd(exmem_rd), .i_exmem_rf(exmem_rf), .i_memwb_rd(memwb_rd), .i_memwb_rf(memwb_rf),
        .i_branch_taken(bt), .o_fwd_a(fa3), .o_fwd_b(fb3), .o_fwd_c(fc3),
        .o_pc_le(pc3), .o_ifid_le(ifle3), .o_ifid_clr(ifclr3), .o_idex_nop(nop3), .o_stall_count(sc3)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] ref_fwd(input logic u, input logic [3:0] s);
        logic [3:0] rds [3];
        logic       wr  [3];
        rds = '{idex_rd, exmem_rd, memwb_rd};
        wr  = '{idex_rf && !idex_load, exmem_rf, memwb_rf};
        if (!clr || !u || s == 4'hF) return 2'b00;
        for (int k = 0; k < 3; k++)
            if (wr[k] && rds[k] == s) return 2'(k + 1);
        return 2'b00;
    endfunction

    function automatic logic ref_haz();
        logic [3:0] srcs [3];
        logic       uses [3];
        srcs = '{rn, rm, rs};
        uses = '{ua, ub, uc};
        if (!(idex_load && idex_rf)) return 1'b0;
        for (int k = 0; k < 3; k++)
            if (uses[k] && srcs[k] != 4'hF && srcs[k] == idex_rd) return 1'b1;
        return 1'b0;
    endfunction

    task automatic chk_inst(input string nm, input int rem, input int cnt,
                            input logic [1:0] fa, input logic [1:0] fb, input logic [1:0] fc,
                            input logic pc, input logic ifle, input logic ifclr, input logic nop,
                            input logic [15:0] sc);
        logic stalling;
        int   exp_sc;
        stalling = clr && (rem > 0 || ref_haz());
`ifdef HAZARD_STALL_COUNTER_EN
        exp_sc = cnt;
`else
        exp_sc = 0;
`endif
        chk({nm, "_fwd_a"}, 32'(fa), 32'(ref_fwd(ua, rn)));
        chk({nm, "_fwd_b"}, 32'(fb), 32'(ref_fwd(ub, rm)));
        chk({nm, "_fwd_c"}, 32'(fc), 32'(ref_fwd(uc, rs)));
        chk({nm, "_pc_le"}, 32'(pc), 32'(clr && !stalling));
        chk({nm, "_ifid_le"}, 32'(ifle), 32'(clr && !stalling));
        chk({nm, "_ifid_clr"}, 32'(ifclr), 32'(clr && !stalling && bt));
        chk({nm, "_idex_nop"}, 32'(nop), 32'(!clr || stalling));
        chk({nm, "_stall_count"}, 32'(sc), 32'(exp_sc));
    endtask

    task automatic advance_model(inout int rem, inout int cnt, input int lat, input int cmax);
        if (!clr) begin
            rem = 0;
            cnt = 0;
        end else begin
            if (rem > 0 || ref_haz()) cnt = (cnt < cmax) ? cnt + 1 : cmax;
            if (rem > 0) rem = rem - 1;
            else if (ref_haz()) rem = lat - 1;
        end
    endtask

    // Inputs are already applied; check, step the model, then cross the clock edge.
    task automatic cycle();
        #1;
        chk_inst("lat1", rem1, cnt1, fa1, fb1, fc1, pc1, ifle1, ifclr1, nop1, sc1);
        chk_inst("lat3", rem3, cnt3, fa3, fb3, fc3, pc3, ifle3, ifclr3, nop3, 16'(sc3));
        advance_model(rem1, cnt1, 1, 65535);
        advance_model(rem3, cnt3, 3, 7);
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        {rn, rm, rs} = {4'd0, 4'd0, 4'd0};
        {ua, ub, uc} = 3'b000;
        {idex_rd, exmem_rd, memwb_rd} = {4'd0, 4'd0, 4'd0};
        {idex_rf, idex_load, exmem_rf, memwb_rf, bt} = 5'b0;
    endtask

    initial begin
        int stalls;
        clr = 1'b0;
        quiet();
        @(posedge clk);
        #1;
        #1;
        chk("rst_pc_le", 32'(pc3), 32'd0);
        chk("rst_idex_nop", 32'(nop3), 32'd1);
        cycle();
        clr = 1'b1;

        idex_rf = 1'b1; idex_rd = 4'd3; rn = 4'd3; ua = 1'b1;
        #1;
        chk("fwd_ex_a", 32'(fa1), 32'd1);
        chk("fwd_ex_pc_le", 32'(pc1), 32'd1);
        cycle();

        quiet();
        idex_rf = 1'b1; idex_rd = 4'd3; exmem_rf = 1'b1; exmem_rd = 4'd3; rm = 4'd3; ub = 1'b1;
        #1; chk("fwd_nearest_b", 32'(fb1), 32'd1);
        cycle();
        idex_rf = 1'b0;
        #1; chk("fwd_mem_b", 32'(fb1), 32'd2);
        cycle();
        rm = 4'hF;
        #1; chk("fwd_pc_b", 32'(fb1), 32'd0);
        cycle();

        quiet();
        idex_load = 1'b1; idex_rf = 1'b1; idex_rd = 4'd5; rs = 4'd5; uc = 1'b1; bt = 1'b1;
        #1; chk("haz_nop", 32'(nop1), 32'd1);
        cycle();
        idex_load = 1'b0; idex_rf = 1'b0; exmem_rf = 1'b1; exmem_rd = 4'd5;
        #1;
        chk("post_haz_fwd_c", 32'(fc1), 32'd2);
        chk("post_haz_pc_le", 32'(pc1), 32'd1);
        stalls = 1;
        for (int i = 0; i < 4 && pc3 == 1'b0; i++) begin
            chk("stall_branch_ignored", 32'(ifclr3), 32'd0);
            stalls++;
            cycle();
        end
        chk("lat3_stall_cycles", 32'(stalls), 32'd3);
        chk("lat3_run_branch", 32'(ifclr3), 32'd1);
        cycle();
        bt = 1'b0;
        #1; chk("branch_one_cycle", 32'(ifclr1), 32'd0);
        cycle();

        quiet();
        idex_load = 1'b1; idex_rf = 1'b1; idex_rd = 4'd2; rn = 4'd2; ua = 1'b1;
        cycle();
        quiet();
        clr = 1'b0;
        #1;
        chk("midstall_rst_pc_le", 32'(pc3), 32'd0);
        chk("midstall_rst_nop", 32'(nop3), 32'd1);
        cycle();
        clr = 1'b1;
        #1; chk("after_rst_pc_le", 32'(pc3), 32'd1);
        cycle();

        for (int n = 0; n < 500; n++) begin
            rn = ($urandom_range(0, 7) == 0) ? 4'hF : 4'($urandom_range(0, 3));
            rm = ($urandom_range(0, 7) == 0) ? 4'hF : 4'($urandom_range(0, 3));
            rs = ($urandom_range(0, 7) == 0) ? 4'hF : 4'($urandom_range(0, 3));
            {ua, ub, uc} = 3'($urandom);
            idex_rd  = ($urandom_range(0, 9) == 0) ? 4'hF : 4'($urandom_range(0, 3));
            exmem_rd = 4'($urandom_range(0, 3));
            memwb_rd = 4'($urandom_range(0, 3));
            {idex_rf, idex_load, exmem_rf, memwb_rf, bt} = 5'($urandom);
            clr = ($urandom_range(0, 40) != 0);
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
